// File: rtl/decoder_rx_if.sv
// decoder_rx_if: downstream valid/ready handshake carrying decoded symbols.
//   dec_y     - one-hot decoded word at the FIFO head (8'h00 when idle)
//   dec_code  - binary index of the FIFO head entry (3'd0 when idle)
//   out_valid - head entry present
//   out_ready - consumer accepts the head when out_valid & out_ready
// master: the decoder (drives data/valid); slave: the consumer (drives ready).
interface decoder_rx_if;
    logic [7:0] dec_y;
    logic [2:0] dec_code;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output dec_y,
        output dec_code,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  dec_y,
        input  dec_code,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/decoder_rx.sv
// decoder_rx: receive end of the 4-line encoded link.
// Captures a3 (symbol present) and a2..a0 (index) every cycle, writes valid
// symbols into a first-word-fall-through FIFO and presents them one-hot over
// a valid/ready handshake. Keeps accepted and dropped symbol counters.
// Ports:
//   clk, rst_n      - clock, synchronous active-low reset
//   in_a3value..a0  - encoded symbol lines
//   bus (master)    - dec_y / dec_code / out_valid / out_ready handshake
//   fifo_level      - current entry count 0..FIFO_DEPTH
//   sym_cnt         - symbols written to the FIFO (wrapping)
//   ovf_cnt         - symbols dropped on a full FIFO (saturating)
//   clr_cnt         - synchronous clear of both counters
module decoder_rx #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_a3value,
    input  logic                          in_a2value,
    input  logic                          in_a1value,
    input  logic                          in_a0value,
    decoder_rx_if.master                  bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              sym_cnt,
    output logic [CNT_W-1:0]              ovf_cnt,
    input  logic                          clr_cnt
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic             cap_a3;
    logic [2:0]       cap_code;
    logic [2:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic empty;
    logic full;
    logic pop;
    logic push;
    logic drop;
    logic [2:0] head_code;

    // Stage 1: unconditional capture of the link lines.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_a3   <= 1'b0;
            cap_code <= '0;
        end else begin
            cap_a3   <= in_a3value;
            cap_code <= {in_a2value, in_a1value, in_a0value};
        end
    end

    assign empty = (fifo_level == '0);
    assign full  = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign pop   = !empty && bus.out_ready;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push  = cap_a3 && (!full || pop);
    assign drop  = cap_a3 && full && !pop;

    // Storage has no reset; validity is tracked solely by fifo_level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cap_code;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + LVL_W'(1);
            end else if (pop && !push) begin
                fifo_level <= fifo_level - LVL_W'(1);
            end
        end
    end

    // Clear takes priority over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_cnt) begin
            sym_cnt <= '0;
            ovf_cnt <= '0;
        end else begin
            if (push) begin
                sym_cnt <= sym_cnt + CNT_W'(1);
            end
            if (drop && (ovf_cnt != '1)) begin
                ovf_cnt <= ovf_cnt + CNT_W'(1);
            end
        end
    end

    // Outputs depend only on registered state (level, read pointer, memory).
    always_comb begin
        head_code     = '0;
        bus.out_valid = 1'b0;
        bus.dec_code  = '0;
        bus.dec_y     = '0;
        if (!empty) begin
            head_code     = mem[rd_ptr];
            bus.out_valid = 1'b1;
            bus.dec_code  = head_code;
            bus.dec_y     = 8'd1 << head_code;
        end
    end
endmodule

// File: tb/tb_decoder_rx.sv
// tb_decoder_rx: directed self-checking bench for decoder_rx (FIFO_DEPTH=4,
// CNT_W=8). Inputs change 1 time unit after each rising edge; outputs are
// sampled at that same point, well away from the next edge.
module tb_decoder_rx;
    logic       clk;
    logic       rst_n;
    logic       in_a3value;
    logic       in_a2value;
    logic       in_a1value;
    logic       in_a0value;
    logic [2:0] fifo_level;
    logic [7:0] sym_cnt;
    logic [7:0] ovf_cnt;
    logic       clr_cnt;

    int checks;
    int failures;

    decoder_rx_if bus ();

    decoder_rx #(
        .FIFO_DEPTH (4),
        .CNT_W      (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_a3value (in_a3value),
        .in_a2value (in_a2value),
        .in_a1value (in_a1value),
        .in_a0value (in_a0value),
        .bus        (bus),
        .fifo_level (fifo_level),
        .sym_cnt    (sym_cnt),
        .ovf_cnt    (ovf_cnt),
        .clr_cnt    (clr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a3, input logic [2:0] code);
        in_a3value = a3;
        {in_a2value, in_a1value, in_a0value} = code;
    endtask

    logic [2:0] exp_order [4];

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        clr_cnt    = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 3'd0);
        tick();
        tick();

        // Reset state
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_dec_y", 32'(bus.dec_y), 32'h00);
        check("rst_code",  32'(bus.dec_code), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_sym",   32'(sym_cnt), 32'd0);
        check("rst_ovf",   32'(ovf_cnt), 32'd0);
        rst_n = 1'b1;

        // Single symbol, code 5: captured at edge N, visible after edge N+1
        drive(1'b1, 3'd5);
        tick();
        drive(1'b0, 3'd0);
        check("single_lat_valid", 32'(bus.out_valid), 32'd0);
        tick();
        check("single_valid", 32'(bus.out_valid), 32'd1);
        check("single_dec_y", 32'(bus.dec_y), 32'h20);
        check("single_code",  32'(bus.dec_code), 32'd5);
        check("single_sym",   32'(sym_cnt), 32'd1);
        check("single_level", 32'(fifo_level), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        check("single_pop_valid", 32'(bus.out_valid), 32'd0);
        check("single_pop_dec_y", 32'(bus.dec_y), 32'h00);
        bus.out_ready = 1'b0;

        // Clear counters so the sweep count starts from zero
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("clr_sym", 32'(sym_cnt), 32'd0);

        // Sweep codes 0..7 back-to-back with the consumer always ready
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) drive(1'b1, 3'(i));
            else       drive(1'b0, 3'd0);
            tick();
            if (i >= 1 && i <= 8) begin
                check($sformatf("sweep_valid_%0d", i - 1), 32'(bus.out_valid), 32'd1);
                check($sformatf("sweep_dec_y_%0d", i - 1), 32'(bus.dec_y), 32'd1 << (i - 1));
            end
        end
        check("sweep_empty", 32'(bus.out_valid), 32'd0);
        check("sweep_sym",   32'(sym_cnt), 32'd8);
        check("sweep_ovf",   32'(ovf_cnt), 32'd0);

        // Overflow: six symbols into a 4-deep FIFO, no consumer
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 3'(i));
            tick();
        end
        drive(1'b0, 3'd0);
        tick();
        check("ovf_level", 32'(fifo_level), 32'd4);
        check("ovf_cnt",   32'(ovf_cnt), 32'd2);
        check("ovf_sym",   32'(sym_cnt), 32'd12);
        check("ovf_head",  32'(bus.dec_code), 32'd1);

        // Full FIFO with simultaneous push (code 7) and pop
        drive(1'b1, 3'd7);
        tick();
        drive(1'b0, 3'd0);
        bus.out_ready = 1'b1;
        tick();
        check("fullpp_level", 32'(fifo_level), 32'd4);
        check("fullpp_ovf",   32'(ovf_cnt), 32'd2);
        check("fullpp_sym",   32'(sym_cnt), 32'd13);
        exp_order[0] = 3'd2;
        exp_order[1] = 3'd3;
        exp_order[2] = 3'd4;
        exp_order[3] = 3'd7;
        for (int j = 0; j < 4; j++) begin
            check($sformatf("drain_valid_%0d", j), 32'(bus.out_valid), 32'd1);
            check($sformatf("drain_code_%0d", j), 32'(bus.dec_code), 32'(exp_order[j]));
            tick();
        end
        check("drain_empty", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;

        // Idle link: a3=0 with arbitrary index bits
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 3'($urandom_range(0, 7)));
            tick();
            check($sformatf("idle_valid_%0d", i), 32'(bus.out_valid), 32'd0);
        end
        drive(1'b0, 3'd0);
        tick();
        check("idle_sym",   32'(sym_cnt), 32'd13);
        check("idle_level", 32'(fifo_level), 32'd0);

        // Saturation: 304 writes with no consumer -> 4 accepted, 300 dropped
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        for (int i = 0; i < 304; i++) begin
            drive(1'b1, 3'(i));
            tick();
        end
        drive(1'b0, 3'd0);
        tick();
        check("sat_ovf",   32'(ovf_cnt), 32'hFF);
        check("sat_sym",   32'(sym_cnt), 32'd4);
        check("sat_level", 32'(fifo_level), 32'd4);

        // Wrap: 256 accepted writes through a full FIFO drained every cycle
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("wrap_clr_ovf", 32'(ovf_cnt), 32'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 3'(i));
            tick();
            if (i == 255) check("wrap_sym_255", 32'(sym_cnt), 32'd255);
        end
        drive(1'b0, 3'd0);
        bus.out_ready = 1'b0;
        tick();
        check("wrap_sym",   32'(sym_cnt), 32'd0);
        check("wrap_ovf",   32'(ovf_cnt), 32'd0);
        check("wrap_level", 32'(fifo_level), 32'd4);

        // Drain, then clear coincident with a write
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        bus.out_ready = 1'b0;
        check("pre_clr_level", 32'(fifo_level), 32'd0);
        drive(1'b1, 3'd2);
        tick();
        drive(1'b1, 3'd3);
        tick();
        check("pre_clr_sym", 32'(sym_cnt), 32'd1);
        drive(1'b0, 3'd0);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("clrw_sym",   32'(sym_cnt), 32'd0);
        check("clrw_ovf",   32'(ovf_cnt), 32'd0);
        check("clrw_level", 32'(fifo_level), 32'd2);
        drive(1'b1, 3'd6);
        tick();
        drive(1'b0, 3'd0);
        tick();
        check("post_clr_level", 32'(fifo_level), 32'd3);
        check("post_clr_sym",   32'(sym_cnt), 32'd1);
        check("post_clr_head",  32'(bus.dec_code), 32'd2);

        // Reset with three buffered entries
        rst_n = 1'b0;
        tick();
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_level", 32'(fifo_level), 32'd0);
        check("midrst_dec_y", 32'(bus.dec_y), 32'h00);
        check("midrst_sym",   32'(sym_cnt), 32'd0);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/decoder_rx.md
Name: decoder_rx

Overview:
- Receive end of the 4-line encoded link: samples the encoded symbol lines (a3 = symbol-present, a2..a0 = binary index) and decodes each symbol back to an 8-bit one-hot word (index 5 -> 8'b00100000).
- Decoded words are buffered in a small FIFO and presented to the downstream consumer over a valid/ready handshake.
- Keeps accepted-symbol and dropped-symbol (overflow) counters for link diagnostics.

Parameters:
- FIFO_DEPTH, 4, number of decoded-word entries; power of 2, minimum 2.
- CNT_W, 8, width of sym_cnt and ovf_cnt.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_a3value  input  1  symbol-present line; 1 = a2..a0 carry a valid index this cycle.
- in_a2value  input  1  encoded index bit 2 (MSB).
- in_a1value  input  1  encoded index bit 1.
- in_a0value  input  1  encoded index bit 0 (LSB).
- dec_y  output  8  one-hot decoded word at FIFO head; 8'h00 when out_valid=0.
- dec_code  output  3  binary index of FIFO head entry; 3'd0 when out_valid=0.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts head when out_valid & out_ready.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current entry count, 0..FIFO_DEPTH.
- sym_cnt  output  CNT_W  symbols written to FIFO; wraps modulo 2^CNT_W.
- ovf_cnt  output  CNT_W  symbols dropped because FIFO full; saturates at all-ones.
- clr_cnt  input  1  synchronous clear of sym_cnt and ovf_cnt.

Behaviour:
- Reset (rst_n=0 at a rising edge): input capture register cleared (captured a3=0, so no spurious symbol), FIFO flushed, fifo_level=0, out_valid=0, dec_y=8'h00, dec_code=0, sym_cnt=0, ovf_cnt=0. Reset mid-operation discards all buffered entries; first post-reset input sample is taken at the first edge with rst_n=1.
- Stage 1 (capture): all four in_* lines registered every cycle, unconditionally.
- Stage 2 (decode/write): if captured a3=1, the symbol is valid; stored entry is the 3-bit code; dec_y = 8'b1 << code. Captured a3=0 -> no write, a2..a0 ignored.
- Latency: lines stable before edge N -> captured at edge N -> written at edge N+1 -> out_valid=1 and dec_y valid after edge N+1 (first-word fall-through; 2 cycles pins-to-output). Back-to-back symbols (a3 held high) are accepted one per cycle.
- Pop: out_valid & out_ready at an edge removes the head; the next entry (if any) appears after the same edge. out_ready while empty has no effect.
- Write when not full: entry stored, sym_cnt += 1 (wrapping).
- Write when full with a simultaneous pop: write accepted, level stays FIFO_DEPTH, sym_cnt += 1.
- Write when full without a pop: symbol dropped, FIFO unchanged, ovf_cnt += 1 unless already all-ones.
- Simultaneous push and pop at any level: level unchanged; order preserved (strict FIFO).
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally; full/empty are derived from fifo_level.
- clr_cnt=1: sym_cnt and ovf_cnt become 0 at that edge; clear wins over a same-cycle increment (that event is not counted). FIFO contents are unaffected.
- All outputs are registered or derived only from registered state; there is no combinational path from in_* or out_ready to any output.

Test Plan:
- Reset then single symbol: a3=1, a2..a0=3'b101 for one cycle -> out_valid rises 2 edges later, dec_y=8'b00100000, dec_code=5, sym_cnt=1, fifo_level=1; pop with out_ready -> out_valid=0, dec_y=8'h00.
- Sweep: codes 0..7 back-to-back with a3=1, out_ready=1 -> dec_y sequence 8'h01,02,04,08,10,20,40,80 on consecutive cycles, no gaps; sym_cnt=8; ovf_cnt=0.
- Overflow: out_ready=0, 6 consecutive symbols (codes 1..6) with FIFO_DEPTH=4 -> fifo_level=4, ovf_cnt=2; drain yields codes 1,2,3,4 only.
- Full with simultaneous push and pop: FIFO full, out_ready=1 while a new symbol arrives -> no drop, ovf_cnt unchanged, level stays 4, order preserved.
- Idle link: a3=0 with random a2..a0 for 20 cycles -> no writes, out_valid=0, sym_cnt unchanged.
- Counter edges: force 300 drops with CNT_W=8 -> ovf_cnt holds 8'hFF; 256 accepted symbols -> sym_cnt wraps to 0; clr_cnt coincident with a write -> both counters 0 at that edge; rst_n=0 with 3 buffered entries -> out_valid=0, fifo_level=0 at the next edge.
